uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART byte transmitter among several requesters (message sources such as the "Hello" character rotator, status reporters and echo paths) in the digital-clock UART controller. It grants the transmitter to one requester for a whole message using round-robin priority. It feeds bytes one at a time with a start/done handshake and releases the grant on the last byte, on request withdrawal, or on a transmitter timeout. It sits between the message sources and the UART_Tx-style serializer, in the system clock domain.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 9, byte width passed to the transmitter
- TIMEOUT, 1000000, i_clk cycles allowed between o_tx_start and i_tx_done before forced release (≥2)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_req  in  N_REQ  per-requester byte-valid; held high with stable data until acked
- i_data  in  N_REQ*DATA_W  requester r's byte on bits [r*DATA_W +: DATA_W]
- i_last  in  N_REQ  marks the presented byte as final of the message
- o_ack  out  N_REQ  one-cycle pulse: requester's current byte accepted
- o_grant  out  N_REQ  one-hot owner of the transmitter, 0 when free
- o_tx_start  out  1  one-cycle pulse: transmitter loads o_tx_data
- o_tx_data  out  DATA_W  registered byte, stable from start until next start
- i_tx_done  in  1  one-cycle pulse from transmitter (synchronous to i_clk): byte finished
- o_busy  out  1  high whenever o_grant ≠ 0
- o_timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, WAIT. The SEND action is a registered transition, not a dwell state.
- Reset: state IDLE; all outputs 0; round-robin pointer = 0; timeout counter = 0; latched-last = 0.
- IDLE, any i_req high: select the first requester at or after the pointer (wrapping N_REQ-1→0). On the next edge:
  - o_grant = that requester (one-hot)
  - o_tx_data = its byte; latched-last = its i_last
  - o_tx_start = 1 and its o_ack = 1, both for one cycle
  - state → WAIT; counter cleared
- WAIT:
  - The counter increments each cycle. i_tx_done is honored only in WAIT.
  - i_tx_done with latched-last = 1: release.
  - i_tx_done with latched-last = 0 and owner's i_req high: reload on the next edge (new data, start and ack pulses), stay WAIT, counter cleared.
  - i_tx_done with latched-last = 0 and owner's i_req low: release (message abandoned).
  - Counter reaches TIMEOUT-1 without i_tx_done: release, and o_timeout pulses for one cycle.
- Release:
  - On the next edge: o_grant = 0, state IDLE, pointer = owner+1 mod N_REQ.
  - No new grant is issued on the release edge.
- Non-owner requests wait. i_req/i_data/i_last of non-owners are ignored.
- o_ack never pulses for a requester whose i_req is low.

## Timing
- Latency from IDLE request to o_tx_start/o_ack/o_grant: 1 cycle.
- Latency from i_tx_done to the next byte's o_tx_start within a message: 1 cycle.
- Release: grant drops 1 cycle after the done/timeout; the earliest next grant is 1 cycle after that. Minimum gap between messages is 2 cycles.
- Requester presents its next byte no later than the cycle after o_ack. The arbiter samples it only on the cycle i_tx_done is seen.
- i_tx_done and timeout in the same cycle: done wins, no o_timeout.
- i_tx_done arriving while in IDLE: ignored.
- Asynchronous reset mid-message: outputs clear immediately and the grant is lost. The requester is not acked for the in-flight byte.
- Counter is wide enough for TIMEOUT-1 and never wraps.

## Test plan
- Reset: hold i_rst = 0 with all i_req high → o_grant, o_ack, o_tx_start, o_busy, o_timeout all 0. Release → r0 granted 1 cycle later with o_tx_data = r0's byte.
- Single message: r1 sends 0x48, 0x65, 0x6c, 0x6c, 0x6f (last on 0x6f), with done 10 cycles after each start → five starts with those bytes in order, five acks to r1. Grant drops 1 cycle after the fifth done; pointer = 2.
- Round-robin: r0, r2 and r3 all request one-byte messages continuously → grant order r0, r2, r3, r0. Each start is 2 cycles after the previous done.
- Abandon: r2 drops i_req after its 2nd ack without last → release after the 2nd done, no 3rd start, pointer = 3.
- Timeout: TIMEOUT = 16, never assert i_tx_done → o_timeout pulses 16 cycles after start, grant released. With done and the limit coincident → no o_timeout and normal continuation.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter among requesters
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 9,
    parameter int TIMEOUT = 1000000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    input  logic [N_REQ-1:0]          i_last,
    output logic [N_REQ-1:0]          o_ack,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                timeout_q, timeout_d;

    logic [PTR_W-1:0]    sel;
    logic                found;
    int                  idx;
    logic                load;
    logic [PTR_W-1:0]    load_idx;
    logic                rel;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        data_d    = data_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        load      = 1'b0;
        load_idx  = sel;
        rel       = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) load = 1'b1;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (i_tx_done) begin
                    if (!last_q && i_req[owner_q]) begin
                        load     = 1'b1;
                        load_idx = owner_q;
                    end else begin
                        rel = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            grant_d = N_REQ'(1) << load_idx;
            ack_d   = N_REQ'(1) << load_idx;
            owner_d = load_idx;
            data_d  = i_data[int'(load_idx)*DATA_W +: DATA_W];
            last_d  = i_last[load_idx];
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
        end

        // Release never grants in the same edge; IDLE re-arbitrates one cycle later.
        if (rel) begin
            grant_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
            ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            data_q    <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            data_q    <= data_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_ack      = ack_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_busy     = |grant_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 9;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_grant;
    logic           o_tx_start;
    logic [W-1:0]   o_tx_data;
    logic           i_tx_done;
    logic           o_busy;
    logic           o_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .i_last(i_last),
        .o_ack(o_ack), .o_grant(o_grant), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done(i_tx_done), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_byte(input int r, input logic [W-1:0] b, input logic last);
        i_data[r*W +: W] = b;
        i_last[r]        = last;
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (!o_tx_start && n < 40) begin
            tick();
            n++;
        end
        if (!o_tx_start) check({tag, "_no_start"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        repeat (2) tick();
        i_rst = 1'b1;
    endtask

    logic [W-1:0] msg [5];
    logic [N-1:0] rr_grant [4];
    logic [W-1:0] rr_data [4];
    int n;
    int k;

    initial begin
        msg      = '{9'h048, 9'h065, 9'h06c, 9'h06c, 9'h06f};
        rr_grant = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        rr_data  = '{9'h010, 9'h012, 9'h013, 9'h010};
        i_rst = 1'b0; i_req = '0; i_data = '0; i_last = '0; i_tx_done = 1'b0;

        // Reset held with every requester active
        i_req = 4'hf;
        set_byte(0, 9'h1a0, 1'b1); set_byte(1, 9'h031, 1'b1);
        set_byte(2, 9'h032, 1'b1); set_byte(3, 9'h033, 1'b1);
        repeat (3) tick();
        check("rst_grant",   32'(o_grant),    32'd0);
        check("rst_ack",     32'(o_ack),      32'd0);
        check("rst_start",   32'(o_tx_start), 32'd0);
        check("rst_busy",    32'(o_busy),     32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        i_rst = 1'b1;
        tick();
        check("rst_first_grant", 32'(o_grant),    32'b0001);
        check("rst_first_ack",   32'(o_ack),      32'b0001);
        check("rst_first_start", 32'(o_tx_start), 32'd1);
        check("rst_first_data",  32'(o_tx_data),  32'h1a0);
        check("rst_first_busy",  32'(o_busy),     32'd1);
        i_req = '0;
        tick();
        check("ack_one_cycle", 32'(o_ack),      32'd0);
        check("start_one_cyc", 32'(o_tx_start), 32'd0);
        pulse_done();
        check("rst_rel_grant", 32'(o_grant), 32'd0);
        check("rst_rel_busy",  32'(o_busy),  32'd0);
        tick();

        // Done while idle must be ignored
        pulse_done();
        check("idle_done_start", 32'(o_tx_start), 32'd0);
        check("idle_done_grant", 32'(o_grant),    32'd0);

        // Five-byte message from r1 (pointer is 1)
        set_byte(1, msg[0], 1'b0);
        i_req = 4'b0010;
        for (int b = 0; b < 5; b++) begin
            wait_start("msg", n);
            if (b > 0) check("msg_reload_lat", 32'(n), 32'd0);
            check("msg_data",  32'(o_tx_data), 32'(msg[b]));
            check("msg_ack",   32'(o_ack),     32'b0010);
            check("msg_grant", 32'(o_grant),   32'b0010);
            if (b < 4) set_byte(1, msg[b+1], (b == 3));
            else       i_req = '0;
            repeat (10) tick();
            pulse_done();
        end
        check("msg_rel_grant", 32'(o_grant),    32'd0);
        check("msg_rel_start", 32'(o_tx_start), 32'd0);

        // Pointer is now 2: r2 wins over r0
        set_byte(0, 9'h100, 1'b1); set_byte(2, 9'h102, 1'b1);
        i_req = 4'b0101;
        wait_start("ptr2", n);
        check("ptr2_grant", 32'(o_grant),   32'b0100);
        check("ptr2_data",  32'(o_tx_data), 32'h102);
        i_req = '0;
        pulse_done();
        tick();

        // Round-robin among r0, r2, r3 from a fresh pointer
        do_reset();
        set_byte(0, 9'h010, 1'b1); set_byte(2, 9'h012, 1'b1); set_byte(3, 9'h013, 1'b1);
        i_req = 4'b1101;
        for (int r = 0; r < 4; r++) begin
            wait_start("rr", n);
            check("rr_grant", 32'(o_grant),   32'(rr_grant[r]));
            check("rr_data",  32'(o_tx_data), 32'(rr_data[r]));
            if (r > 0) check("rr_gap", 32'(n + 1), 32'd2);
            if (r == 3) i_req = '0;
            repeat (2) tick();
            pulse_done();
        end
        tick();

        // Abandon: r2 drops request after its second ack (pointer is 1)
        set_byte(2, 9'h0a1, 1'b0);
        i_req = 4'b0100;
        wait_start("ab", n);
        check("ab_data0", 32'(o_tx_data), 32'h0a1);
        set_byte(2, 9'h0a2, 1'b0);
        repeat (3) tick();
        pulse_done();
        check("ab_start2", 32'(o_tx_start), 32'd1);
        check("ab_data1",  32'(o_tx_data),  32'h0a2);
        check("ab_ack2",   32'(o_ack),      32'b0100);
        i_req = '0;
        repeat (3) tick();
        pulse_done();
        check("ab_rel_grant",   32'(o_grant),    32'd0);
        check("ab_rel_start",   32'(o_tx_start), 32'd0);
        check("ab_rel_timeout", 32'(o_timeout),  32'd0);
        tick();
        check("ab_no_third", 32'(o_tx_start), 32'd0);
        set_byte(1, 9'h0b1, 1'b1); set_byte(3, 9'h0b3, 1'b1);
        i_req = 4'b1010;
        wait_start("ab_ptr", n);
        check("ab_ptr3_grant", 32'(o_grant), 32'b1000);
        i_req = '0;
        pulse_done();
        tick();

        // Timeout: r0 never sees done (pointer is 0)
        set_byte(0, 9'h155, 1'b0);
        i_req = 4'b0001;
        wait_start("to", n);
        check("to_grant", 32'(o_grant), 32'b0001);
        k = 0;
        while (!o_timeout && k < 40) begin
            tick();
            k++;
        end
        i_req = '0;
        check("to_latency",   32'(k),       32'd16);
        check("to_rel_grant", 32'(o_grant), 32'd0);
        tick();
        check("to_one_pulse", 32'(o_timeout), 32'd0);

        // Done coincident with the timeout limit (pointer is 1)
        set_byte(1, 9'h0c1, 1'b0);
        i_req = 4'b0010;
        wait_start("co", n);
        set_byte(1, 9'h0c2, 1'b1);
        repeat (15) tick();
        pulse_done();
        check("co_timeout", 32'(o_timeout),  32'd0);
        check("co_start",   32'(o_tx_start), 32'd1);
        check("co_data",    32'(o_tx_data),  32'h0c2);
        check("co_grant",   32'(o_grant),    32'b0010);
        i_req = '0;
        repeat (3) tick();
        pulse_done();
        check("co_rel_grant",   32'(o_grant),   32'd0);
        check("co_rel_timeout", 32'(o_timeout), 32'd0);
        tick();

        // Asynchronous reset mid-message
        set_byte(2, 9'h0d2, 1'b0);
        i_req = 4'b0100;
        wait_start("ar", n);
        #2 i_rst = 1'b0;
        #1;
        check("ar_grant", 32'(o_grant), 32'd0);
        check("ar_busy",  32'(o_busy),  32'd0);
        check("ar_start", 32'(o_tx_start), 32'd0);
        i_req = '0;
        tick();
        i_rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
